bin_mult_seq: RTL and testbench

BIN_MULT_SEQ -- requirements
Module: bin_mult_seq

---
 rtl/bnn_pkg.sv | 38 +++
 rtl/bin_mult_seq.sv | 129 ++++++++++++
 tb/tb_bin_mult_seq.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-network sequencer.
//   N_ROWS / ROW_W : window geometry (7 rows of 7 bits)
//   OP_*           : bit positions inside the 5-bit datapath opcode
//   state_t        : sequencer FSM states
//   op_acc()       : builds the accumulate opcode for a given row
package bnn_pkg;

  localparam int N_ROWS = 7;
  localparam int ROW_W  = 7;
  localparam int CNT_W  = 3;
  localparam int OP_W   = 5;

  localparam int OP_CLR     = 0;
  localparam int OP_SEL_LSB = 1;
  localparam int OP_SEL_MSB = 3;
  localparam int OP_ADD     = 4;

  localparam logic [OP_W-1:0] OP_NONE  = 5'b00000;
  localparam logic [OP_W-1:0] OP_CLEAR = 5'b00001;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CLR  = 3'd2,
    ACC  = 3'd3,
    CAPT = 3'd4
  } state_t;

  // Accumulate opcode: add bit set, row select in [3:1], clear bit low.
  function automatic logic [OP_W-1:0] op_acc(input logic [CNT_W-1:0] row);
    logic [OP_W-1:0] op;
    op = OP_NONE;
    op[OP_ADD] = 1'b1;
    op[OP_SEL_MSB:OP_SEL_LSB] = row;
    return op;
  endfunction

endpackage

// File: rtl/bin_mult_seq.sv
// Sequencer for one 7x7 binary window evaluation.
// Optionally streams 7 weight rows into the datapath, clears its
// accumulator, steps through the 7 rows accumulating, then captures the
// accumulator into result and pulses done.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   start, load_w    : request an evaluation (load_w = stream new weights)
//   abort            : cancel and return to IDLE
//   w_valid, w_data  : weight row source
//   w_ready          : block accepts a weight row (LOAD only)
//   w_en, w_input    : datapath weight shift enable / row
//   opcode           : datapath command {add, row[2:0], clear}
//   popcnt_add       : datapath accumulator value
//   busy, done       : status; done is a one-cycle pulse with result valid
//   result           : captured accumulator, held until the next done
module bin_mult_seq
  import bnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    load_w,
  input  logic                    abort,
  input  logic                    w_valid,
  input  logic [ROW_W-1:0]        w_data,
  output logic                    w_ready,
  output logic                    w_en,
  output logic [ROW_W-1:0]        w_input,
  output logic [OP_W-1:0]         opcode,
  input  logic signed [ROW_W-1:0] popcnt_add,
  output logic                    busy,
  output logic                    done,
  output logic signed [ROW_W-1:0] result
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ROWS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;   // beat counter in LOAD, row counter in ACC
  logic             beat;

  assign w_ready = (state == LOAD);
  assign beat    = w_valid & w_ready;
  assign w_en    = beat;
  assign w_input = w_data;
  assign busy    = (state != IDLE);

  // NOTE: every register here is written with <= so all of them update
  // from the same pre-edge values; blocking assignments would make the
  // result depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: result is a single register, not a memory, so clearing it on
      // reset is cheap and gives a defined value before the first done.
      state  <= IDLE;
      cnt    <= '0;
      opcode <= OP_NONE;
      done   <= 1'b0;
      result <= '0;
    end else begin
      // Pulse-style outputs default low; the opcode is registered so it
      // lines up with the state it belongs to.
      done   <= 1'b0;
      opcode <= OP_NONE;

      if (abort) begin
        // Abort beats every transition, including a start in IDLE.
        state  <= IDLE;
        cnt    <= '0;
        opcode <= OP_CLEAR;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              cnt <= '0;
              if (load_w) begin
                state <= LOAD;
              end else begin
                state  <= CLR;
                opcode <= OP_CLEAR;
              end
            end
          end

          LOAD: begin
            if (beat) begin
              if (cnt == LAST) begin
                cnt    <= '0;
                state  <= CLR;
                opcode <= OP_CLEAR;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end

          CLR: begin
            cnt    <= '0;
            state  <= ACC;
            opcode <= op_acc('0);
          end

          ACC: begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= CAPT;
            end else begin
              cnt    <= cnt + 1'b1;
              opcode <= op_acc(cnt + 1'b1);
            end
          end

          CAPT: begin
            // The last accumulate has landed by now; done follows in IDLE.
            result <= popcnt_add;
            done   <= 1'b1;
            state  <= IDLE;
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bin_mult_seq.sv
// Directed testbench for bin_mult_seq. A small behavioural datapath
// (7-row weight shift register plus accumulator) can drive popcnt_add;
// each row scores the popcount of its six data columns (bit 6 is the
// bias column and does not score), so a full row of ones scores 6.
module tb_bin_mult_seq;
  import bnn_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic                    load_w = 1'b0;
  logic                    abort = 1'b0;
  logic                    w_valid = 1'b0;
  logic [ROW_W-1:0]        w_data = '0;
  logic                    w_ready;
  logic                    w_en;
  logic [ROW_W-1:0]        w_input;
  logic [OP_W-1:0]         opcode;
  logic signed [ROW_W-1:0] popcnt_add;
  logic                    busy;
  logic                    done;
  logic signed [ROW_W-1:0] result;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // popcnt_add source: forced constant or the behavioural datapath.
  logic                    use_model = 1'b0;
  logic signed [ROW_W-1:0] drv_pop = '0;
  logic [ROW_W-1:0]        w_rows [0:N_ROWS-1];
  logic signed [ROW_W-1:0] acc = '0;

  assign popcnt_add = use_model ? acc : drv_pop;

  always #5 clk = ~clk;

  bin_mult_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_w     (load_w),
    .abort      (abort),
    .w_valid    (w_valid),
    .w_data     (w_data),
    .w_ready    (w_ready),
    .w_en       (w_en),
    .w_input    (w_input),
    .opcode     (opcode),
    .popcnt_add (popcnt_add),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  initial for (int i = 0; i < N_ROWS; i++) w_rows[i] = '0;

  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int i = N_ROWS - 1; i > 0; i--) w_rows[i] <= w_rows[i-1];
      w_rows[0] <= w_input;
    end
    if (opcode[OP_CLR])
      acc <= '0;
    else if (opcode[OP_ADD])
      acc <= acc + ROW_W'($countones(w_rows[opcode[OP_SEL_MSB:OP_SEL_LSB]][5:0]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance until done is seen or the budget runs out; n = ticks taken.
  task automatic wait_done(input int max, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (n < max && !seen) begin
      if (done) seen = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (opcode !== 5'h00) begin errors++; $display("FAIL reset_opcode: got %0h want 00", opcode); end
    checks++; if (result !== 7'sd0) begin errors++; $display("FAIL reset_result: got %0d want 0", result); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL reset_w_ready: got %0b want 0", w_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_compute();
    logic [4:0] exp_op [0:8];
    exp_op = '{5'h01, 5'h10, 5'h12, 5'h14, 5'h16, 5'h18, 5'h1A, 5'h1C, 5'h00};
    use_model = 1'b0;
    drv_pop = 7'sd0;
    start = 1'b1; load_w = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 9) drv_pop = 7'sd23;
      checks++; if (opcode !== exp_op[c-1]) begin errors++; $display("FAIL compute_opcode c%0d: got %0h want %0h", c, opcode, exp_op[c-1]); end
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL compute_status c%0d: busy=%0b done=%0b want 1/0", c, busy, done); end
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL compute_done c10: got %0b want 1", done); end
    checks++; if (result !== 7'sd23) begin errors++; $display("FAIL compute_result: got %0d want 23", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL compute_idle: busy=%0b want 0", busy); end
    drv_pop = 7'sd0;
    tick();
    checks++; if (done !== 1'b0 || result !== 7'sd23) begin errors++; $display("FAIL compute_hold: done=%0b result=%0d want 0/23", done, result); end
  endtask

  task automatic test_busy_start();
    int ndone = 0;
    int dcyc = -1;
    use_model = 1'b0;
    drv_pop = 7'sd5;
    start = 1'b1; load_w = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      start  = (c == 4);
      load_w = (c == 4);
      if (done) begin ndone++; dcyc = c; end
      tick();
    end
    start = 1'b0; load_w = 1'b0;
    checks++; if (ndone !== 1 || dcyc !== 10) begin errors++; $display("FAIL busy_start: dones=%0d at c%0d want 1 at c10", ndone, dcyc); end
    checks++; if (result !== 7'sd5) begin errors++; $display("FAIL busy_start_result: got %0d want 5", result); end
  endtask

  task automatic test_load_stall();
    int t0, b, n;
    bit seen, v;
    use_model = 1'b1;
    t0 = cyc;
    start = 1'b1; load_w = 1'b1;
    tick();
    start = 1'b0; load_w = 1'b0;
    b = 0; v = 1'b1;
    for (int k = 0; k < 40 && b < N_ROWS; k++) begin
      w_valid = v;
      w_data  = ROW_W'(b + 1);
      #1;
      checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL load_w_ready b%0d: got %0b want 1", b, w_ready); end
      checks++; if (w_en !== v) begin errors++; $display("FAIL load_w_en b%0d: got %0b want %0b", b, w_en, v); end
      if (v) begin
        checks++; if (w_input !== ROW_W'(b + 1)) begin errors++; $display("FAIL load_w_input b%0d: got %0h want %0h", b, w_input, b + 1); end
      end
      tick();
      if (v) b++;
      v = !v;
    end
    w_valid = 1'b1;
    #1;
    checks++; if (b !== N_ROWS || cyc - t0 !== 14) begin errors++; $display("FAIL load_beats: %0d beats, now c%0d want 7 and c14", b, cyc - t0); end
    checks++; if (opcode !== 5'h01) begin errors++; $display("FAIL load_then_clr: opcode %0h want 01", opcode); end
    checks++; if (w_ready !== 1'b0 || w_en !== 1'b0) begin errors++; $display("FAIL load_closed: w_ready=%0b w_en=%0b want 0/0", w_ready, w_en); end
    w_valid = 1'b0;
    for (int r = 0; r < N_ROWS; r++) begin
      checks++; if (w_rows[N_ROWS-1-r] !== ROW_W'(r + 1)) begin errors++; $display("FAIL load_order row%0d: got %0h want %0h", N_ROWS - 1 - r, w_rows[N_ROWS-1-r], r + 1); end
    end
    wait_done(30, n, seen);
    checks++; if (!seen || cyc - t0 !== 23) begin errors++; $display("FAIL load_latency: seen=%0b at c%0d want c23", seen, cyc - t0); end
    // Rows 1..7: popcounts 1,1,2,1,2,2,3.
    checks++; if (result !== 7'sd12) begin errors++; $display("FAIL load_result: got %0d want 12", result); end
    tick();
  endtask

  task automatic test_ones();
    int t0, n;
    bit seen;
    use_model = 1'b1;
    t0 = cyc;
    start = 1'b1; load_w = 1'b1;
    tick();
    start = 1'b0; load_w = 1'b0;
    w_valid = 1'b1; w_data = 7'h7F;
    for (int k = 0; k < N_ROWS; k++) tick();
    w_valid = 1'b0;
    wait_done(30, n, seen);
    checks++; if (!seen || cyc - t0 !== 17) begin errors++; $display("FAIL ones_latency: seen=%0b at c%0d want c17", seen, cyc - t0); end
    checks++; if (result !== 7'sd42) begin errors++; $display("FAIL ones_result: got %0d want 42", result); end
    tick();
  endtask

  task automatic test_abort_acc();
    int ndone = 0;
    use_model = 1'b1;
    start = 1'b1; load_w = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    checks++; if (opcode !== 5'h14) begin errors++; $display("FAIL abort_acc_row2: opcode %0h want 14", opcode); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (opcode !== 5'h01 || busy !== 1'b0) begin errors++; $display("FAIL abort_acc_next: opcode=%0h busy=%0b want 01/0", opcode, busy); end
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done) ndone++;
    end
    checks++; if (ndone !== 0 || opcode !== 5'h00 || busy !== 1'b0) begin errors++; $display("FAIL abort_acc_quiet: dones=%0d opcode=%0h busy=%0b want 0/00/0", ndone, opcode, busy); end
    checks++; if (result !== 7'sd42) begin errors++; $display("FAIL abort_acc_result: got %0d want 42", result); end
  endtask

  task automatic test_abort_load();
    int t0, n;
    bit seen;
    use_model = 1'b1;
    start = 1'b1; load_w = 1'b1;
    tick();
    start = 1'b0; load_w = 1'b0;
    w_valid = 1'b1; w_data = 7'h03;
    tick(); tick(); tick();
    w_valid = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (opcode !== 5'h01 || busy !== 1'b0 || w_ready !== 1'b0) begin errors++; $display("FAIL abort_load_next: opcode=%0h busy=%0b w_ready=%0b want 01/0/0", opcode, busy, w_ready); end
    tick();
    t0 = cyc;
    start = 1'b1; load_w = 1'b0;
    tick();
    start = 1'b0;
    wait_done(20, n, seen);
    checks++; if (!seen || cyc - t0 !== 10) begin errors++; $display("FAIL abort_load_latency: seen=%0b at c%0d want c10", seen, cyc - t0); end
    // Three new rows of 0x03 (2 each) plus four old rows of 0x7F (6 each).
    checks++; if (result !== 7'sd30) begin errors++; $display("FAIL abort_load_result: got %0d want 30", result); end
  endtask

  task automatic test_back_to_back();
    int t0, n;
    bit seen;
    use_model = 1'b1;
    t0 = cyc;
    start = 1'b1; load_w = 1'b1;
    tick();
    start = 1'b0; load_w = 1'b0;
    w_valid = 1'b1; w_data = 7'h01;
    wait_done(30, n, seen);
    w_valid = 1'b0;
    checks++; if (!seen || cyc - t0 !== 17) begin errors++; $display("FAIL b2b_load_latency: seen=%0b at c%0d want c17", seen, cyc - t0); end
    checks++; if (result !== 7'sd7) begin errors++; $display("FAIL b2b_load_result: got %0d want 7", result); end
    t0 = cyc;
    start = 1'b1; load_w = 1'b0;
    tick();
    start = 1'b0;
    wait_done(20, n, seen);
    checks++; if (!seen || cyc - t0 !== 10) begin errors++; $display("FAIL b2b_compute_latency: seen=%0b at c%0d want c10", seen, cyc - t0); end
    checks++; if (result !== 7'sd7) begin errors++; $display("FAIL b2b_compute_result: got %0d want 7", result); end
    tick();
  endtask

  task automatic test_start_abort_same();
    start = 1'b1; load_w = 1'b0; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0 || opcode !== 5'h01) begin errors++; $display("FAIL start_abort: busy=%0b opcode=%0h want 0/01", busy, opcode); end
    tick();
    checks++; if (busy !== 1'b0 || opcode !== 5'h00) begin errors++; $display("FAIL start_abort_after: busy=%0b opcode=%0h want 0/00", busy, opcode); end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    use_model = 1'b1;
    start = 1'b1; load_w = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || opcode !== 5'h00 || done !== 1'b0 || result !== 7'sd0) begin errors++; $display("FAIL reset_mid_acc: busy=%0b opcode=%0h done=%0b result=%0d want 0/00/0/0", busy, opcode, done, result); end
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done) ndone++;
    end
    checks++; if (ndone !== 0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid_quiet: dones=%0d busy=%0b want 0/0", ndone, busy); end
    // Reset mid-LOAD: counter must restart so a full load takes 7 beats.
    start = 1'b1; load_w = 1'b1;
    tick();
    start = 1'b0; load_w = 1'b0;
    w_valid = 1'b1; w_data = 7'h7F;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    w_valid = 1'b0;
    #1;
    checks++; if (w_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid_load: w_ready=%0b busy=%0b want 0/0", w_ready, busy); end
  endtask

  initial begin
    test_reset();
    test_compute();
    test_busy_start();
    test_load_stall();
    test_ones();
    test_abort_acc();
    test_abort_load();
    test_back_to_back();
    test_start_abort_same();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
